slot_scoreboard: RTL
====================

// Module: slot_scoreboard
// PURPOSE
//  Downstream consumer of the slot-machine spin stage (10-bit spin value, won, pause).
//  Tracks the player's credit balance: charges a bet at each spin start and pays out on a win.
//  Converts the settled spin value to 3 BCD digits with a sequential double-dabble.
//  Drives three active-low 7-segment displays plus status LEDs on the board top level.
// PARAMETERS
//  START_CREDITS  100  credit balance after reset (0..CREDIT_MAX)
//  BET            1    credits deducted per spin start
//  PAYOUT         10   credits added per paid winning spin
//  CREDIT_MAX     999  saturation ceiling of credits
//  CREDIT_W       10   width of credits output
// PORTS
//  clk        in   1         system clock (50 MHz)
//  rst        in   1         asynchronous reset, active-high
//  spin_val   in   10        spin value from spin stage; stable while pause=1
//  pause      in   1         1 = reels stopped, 0 = spinning
//  won        in   1         win flag from spin stage; valid while pause=1
//  credits    out  CREDIT_W  current credit balance
//  hex2       out  7         hundreds digit, segments {g..a}, active-low
//  hex1       out  7         tens digit
//  hex0       out  7         units digit
//  win_led    out  1         1 = last completed spin was a paid win
//  busy       out  1         1 while in CONV or CREDIT
//  game_over  out  1         1 when credits < BET
// BEHAVIOUR
//  - One clock domain, one async-high reset. Single-cycle operations only; no multi-cycle paths.
//  - Input capture: pause, won and spin_val pass through two flop stages (sync). Edges are
//    detected on stage-2 pause: fall = spin start, rise = spin end.
//  - Reset values: credits=START_CREDITS; hex2/1/0=7'b1000000 ("0"); win_led=0; busy=0;
//    game_over=(START_CREDITS<BET); FSM=IDLE; paid=0; pending=0.
//  - FSM:
//    IDLE -> SPIN on spin start, or on pending=1 with sync pause=0. On entry to SPIN:
//      if credits>=BET then credits-=BET and paid=1; else paid=0.
//      Clear win_led, clear pending. hex2/1/0 = 7'b0111111 (dash).
//    SPIN -> CONV on spin end. Latch spin_val (clamped to 999 if >999) and won.
//      Init the 12-bit BCD shift register to 0 and the cycle counter to 0.
//    CONV: exactly 10 cycles. Each cycle: add 3 to any BCD nibble >=5, then shift left one
//      spin bit (MSB first). After cycle 10 -> CREDIT.
//    CREDIT (1 cycle): load hex2/1/0 from the BCD nibbles.
//      If won&paid: credits=min(credits+PAYOUT, CREDIT_MAX) and win_led=1. -> IDLE.
//  - Latency: stage-2 pause rise -> hex/credits update visible 12 clk later.
//    Pause pin fall -> credits deducted 3 clk later.
//  - Spin start seen in CONV or CREDIT sets pending=1; it is serviced on the first IDLE cycle.
//    A spin end seen while not in SPIN is ignored.
//  - game_over is combinational on registered credits (credits<BET).
//    Spins still proceed when game_over=1, but are unpaid: no deduction, no payout.
//  - Arithmetic: credits math is done CREDIT_W+1 bits wide, then saturated; never wraps below 0.
//  - Reset asserted in any state returns everything to reset values immediately;
//    any in-flight conversion is discarded.
// CONFIGURATION
//  JACKPOT_BONUS_EN defined: a paid win with clamped spin value 777 adds 5*PAYOUT
//    (saturating) instead of PAYOUT.
//  JACKPOT_BONUS_EN undefined: every paid win adds PAYOUT, 777 included.
//  Nothing else changes with the macro.
// TESTING
//  1. rst pulse -> credits=100, hex2/1/0=7'b1000000, game_over=0, busy=0.
//  2. pause 1->0 -> credits=99 at +3 clk, hex=dashes. Then spin_val=222, won=1, pause 0->1 ->
//     at +14 clk from pin: hex all 7'b0100100, credits=109, win_led=1.
//  3. spin_val=1000, won=0 -> hex shows 9,9,9 (7'b0010000); credits unchanged; win_led=0.
//  4. START_CREDITS=0, spin with won=1 -> no deduction, credits stays 0, game_over=1, win_led=0.
//  5. credits=995, paid win -> credits=999 (saturated).
//     pause falls again during CONV -> pending start is serviced right after CREDIT.
//  6. spin 777 won=1: with JACKPOT_BONUS_EN credits 99->149; without 99->109.
//     rst asserted mid-CONV -> all reset values.

Source files
------------

// File: rtl/slot_scoreboard_if.sv
// Slot scoreboard bus: spin-stage inputs plus credit/display/status outputs.
// Ports: spin_val/pause/won in; credits, hex2..0, win_led, busy, game_over out.
interface slot_scoreboard_if #(
  parameter int CREDIT_W = 10
);
  logic [9:0]          spin_val;
  logic                pause;
  logic                won;
  logic [CREDIT_W-1:0] credits;
  logic [6:0]          hex2;
  logic [6:0]          hex1;
  logic [6:0]          hex0;
  logic                win_led;
  logic                busy;
  logic                game_over;

  modport master (
    output spin_val, pause, won,
    input  credits, hex2, hex1, hex0,
    input  win_led, busy, game_over
  );

  modport slave (
    input  spin_val, pause, won,
    output credits, hex2, hex1, hex0,
    output win_led, busy, game_over
  );
endinterface

// File: rtl/slot_scoreboard.sv
// Slot scoreboard: bet/payout credit tracking, double-dabble BCD of the
// settled spin, active-low 7-seg display and status LEDs.
// Ports: clk, rst (async, active-high), bus (slot_scoreboard_if.slave).
// Macro JACKPOT_BONUS_EN: a paid win on 777 adds 5*PAYOUT.
module slot_scoreboard #(
  parameter int START_CREDITS = 100,
  parameter int BET           = 1,
  parameter int PAYOUT        = 10,
  parameter int CREDIT_MAX    = 999,
  parameter int CREDIT_W      = 10
) (
  input logic              clk,
  input logic              rst,
  slot_scoreboard_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_SPIN, S_CONV, S_CREDIT
  } state_t;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = 7'b1111111;
    unique case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t r_state;
  state_t w_next;

  logic r_p1, r_p2, r_p3;
  logic r_w1, r_w2;
  logic [9:0] r_v1, r_v2;

  logic [9:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_won;
  logic        r_paid;
  logic        r_pend;
  logic        r_win;
  logic [CREDIT_W-1:0] r_credits;
  logic [6:0] r_hex2, r_hex1, r_hex0;
`ifdef JACKPOT_BONUS_EN
  logic [9:0] r_val;
`endif

  logic w_fall, w_rise, w_go;
  logic [9:0]  w_clamp;
  logic [11:0] w_adj;
  logic [11:0] w_shift;
  logic [CREDIT_W-1:0] w_bet;
  logic [CREDIT_W:0]   w_add;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_pay;

  // Edges seen on the second sync stage against its delayed copy.
  assign w_fall = r_p3 & ~r_p2;
  assign w_rise = ~r_p3 & r_p2;
  assign w_go   = w_fall | (r_pend & ~r_p2);

  assign w_clamp = (r_v2 > 10'd999) ? 10'd999 : r_v2;
  assign w_bet   = CREDIT_W'(BET);

  // Double-dabble: correct each nibble, then shift in the next spin bit.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5)
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end
  assign w_shift = {w_adj[10:0], r_bin[9]};

  always_comb begin
    w_add = (CREDIT_W+1)'(PAYOUT);
`ifdef JACKPOT_BONUS_EN
    if (r_val == 10'd777)
      w_add = (CREDIT_W+1)'(5 * PAYOUT);
`endif
  end

  assign w_sum = {1'b0, r_credits} + w_add;
  assign w_pay = (w_sum > (CREDIT_W+1)'(CREDIT_MAX))
               ? CREDIT_W'(CREDIT_MAX)
               : w_sum[CREDIT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_go) w_next = S_SPIN;
      S_SPIN:   if (w_rise) w_next = S_CONV;
      S_CONV:   if (r_cnt == 4'd9) w_next = S_CREDIT;
      S_CREDIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1      <= 1'b0;
      r_p2      <= 1'b0;
      r_p3      <= 1'b0;
      r_w1      <= 1'b0;
      r_w2      <= 1'b0;
      r_v1      <= '0;
      r_v2      <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_won     <= 1'b0;
      r_paid    <= 1'b0;
      r_pend    <= 1'b0;
      r_win     <= 1'b0;
      r_credits <= CREDIT_W'(START_CREDITS);
      r_hex2    <= SEG_ZERO;
      r_hex1    <= SEG_ZERO;
      r_hex0    <= SEG_ZERO;
`ifdef JACKPOT_BONUS_EN
      r_val     <= '0;
`endif
    end else begin
      r_p1 <= bus.pause;
      r_p2 <= r_p1;
      r_p3 <= r_p2;
      r_w1 <= bus.won;
      r_w2 <= r_w1;
      r_v1 <= bus.spin_val;
      r_v2 <= r_v1;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            if (r_credits >= w_bet) begin
              r_credits <= r_credits - w_bet;
              r_paid    <= 1'b1;
            end else begin
              r_paid    <= 1'b0;
            end
            r_win  <= 1'b0;
            r_pend <= 1'b0;
            r_hex2 <= SEG_DASH;
            r_hex1 <= SEG_DASH;
            r_hex0 <= SEG_DASH;
          end
        end
        S_SPIN: begin
          if (w_rise) begin
            r_bin <= w_clamp;
            r_won <= r_w2;
            r_bcd <= '0;
            r_cnt <= '0;
`ifdef JACKPOT_BONUS_EN
            r_val <= w_clamp;
`endif
          end
        end
        S_CONV: begin
          r_bcd <= w_shift;
          r_bin <= {r_bin[8:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (w_fall) r_pend <= 1'b1;
        end
        S_CREDIT: begin
          r_hex2 <= seg7(r_bcd[11:8]);
          r_hex1 <= seg7(r_bcd[7:4]);
          r_hex0 <= seg7(r_bcd[3:0]);
          if (r_won && r_paid) begin
            r_credits <= w_pay;
            r_win     <= 1'b1;
          end
          if (w_fall) r_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.credits   = r_credits;
  assign bus.hex2      = r_hex2;
  assign bus.hex1      = r_hex1;
  assign bus.hex0      = r_hex0;
  assign bus.win_led   = r_win;
  assign bus.busy      = (r_state == S_CONV) ||
                         (r_state == S_CREDIT);
  assign bus.game_over = r_credits < w_bet;

endmodule
